// File: rtl/de1_flash_pkg.sv
// Shared types and AMD-style command table for the DE1 byte-mode NOR flash writer.
package de1_flash_pkg;

    typedef enum logic [2:0] {S_RESET, S_IDLE, S_CMD, S_POLL, S_DONE, S_ABORT} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    localparam logic [21:0] CMD_ADDR_AAA = 22'h000AAA;
    localparam logic [21:0] CMD_ADDR_555 = 22'h000555;
    localparam logic [7:0]  DATA_AA = 8'hAA;
    localparam logic [7:0]  DATA_55 = 8'h55;
    localparam logic [7:0]  DATA_A0 = 8'hA0;
    localparam logic [7:0]  DATA_80 = 8'h80;
    localparam logic [7:0]  DATA_30 = 8'h30;
    localparam logic [7:0]  DATA_F0 = 8'hF0;

    localparam int PROG_LEN  = 4;
    localparam int ERASE_LEN = 6;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } bus_cmd_t;

    // Entry idx of the program or sector-erase sequence; the last entry targets the operand.
    function automatic bus_cmd_t cmd_entry(input logic is_erase, input logic [2:0] idx,
                                           input logic [21:0] tgt_addr, input logic [7:0] tgt_data);
        bus_cmd_t c;
        c.addr = CMD_ADDR_AAA;
        c.data = DATA_AA;
        if (is_erase) begin
            case (idx)
                3'd0: ;
                3'd1: begin c.addr = CMD_ADDR_555; c.data = DATA_55; end
                3'd2: begin c.addr = CMD_ADDR_AAA; c.data = DATA_80; end
                3'd3: begin c.addr = CMD_ADDR_AAA; c.data = DATA_AA; end
                3'd4: begin c.addr = CMD_ADDR_555; c.data = DATA_55; end
                default: begin c.addr = tgt_addr; c.data = DATA_30; end
            endcase
        end else begin
            case (idx)
                3'd0: ;
                3'd1: begin c.addr = CMD_ADDR_555; c.data = DATA_55; end
                3'd2: begin c.addr = CMD_ADDR_AAA; c.data = DATA_A0; end
                default: begin c.addr = tgt_addr; c.data = tgt_data; end
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/flash_tick_gen.sv
// Clock divider producing a one-clk tick every CLK_DIV clks; shared with the read controller.
module flash_tick_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/de1_flash_writer.sv
// Programs 16-bit words (two byte programs, low byte first) and erases 64 KB sectors
// on the DE1 NOR flash, with DQ7 data polling and DQ5 timeout detection.
module de1_flash_writer
    import de1_flash_pkg::*;
#(
    parameter int          CLK_DIV     = 5,
    parameter int          RESET_TICKS = 500,
    parameter logic [19:0] POLL_LIMIT  = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_req,
    input  logic [20:0] write_addr,
    input  logic [15:0] write_data,
    input  logic        erase_req,
    input  logic [20:0] erase_addr,
    output logic        write_ready,
    output logic        busy,
    output logic        error,
    output logic [21:0] flash_a,
    output logic [7:0]  flash_d_out,
    input  logic [7:0]  flash_d_in,
    output logic        flash_d_oe,
    output logic        flash_we_n,
    output logic        flash_reset_n,
    output logic        flash_ce_n,
    output logic        flash_oe_n
);

    localparam int RT_W = $clog2(RESET_TICKS + 1);

    // Handshake: write_req/erase_req are accepted on any clk while busy=0 (erase wins a tie);
    // busy rises the next clk and stays high until the clk on which write_ready pulses.
    logic             tick;
    state_t           state;
    phase_t           phase;
    logic [2:0]       cmd_idx;
    logic             op_erase;
    logic             byte_sel;
    logic             dq5_seen;
    logic [20:0]      req_addr;
    logic [15:0]      req_data;
    logic [19:0]      poll_cnt;
    logic [RT_W-1:0]  rst_timer;

    logic [21:0] tgt_addr;
    logic [7:0]  tgt_data;
    logic        poll_exp;
    logic        last_cmd;
    logic [2:0]  next_idx;
    bus_cmd_t    next_cmd;
    bus_cmd_t    start_cmd;
    logic        unused_dq;

    flash_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign flash_ce_n = 1'b0;
    assign unused_dq  = ^{flash_d_in[6], flash_d_in[4:0]};

    always_comb begin
        tgt_addr  = op_erase ? {req_addr[20:15], 16'h0000} : {req_addr, byte_sel};
        tgt_data  = byte_sel ? req_data[15:8] : req_data[7:0];
        poll_exp  = op_erase ? 1'b1 : tgt_data[7];
        last_cmd  = op_erase ? (cmd_idx == 3'(ERASE_LEN - 1)) : (cmd_idx == 3'(PROG_LEN - 1));
        next_idx  = last_cmd ? 3'd0 : cmd_idx + 3'd1;
        next_cmd  = cmd_entry(op_erase, next_idx, tgt_addr, tgt_data);
        start_cmd = cmd_entry(op_erase, 3'd0, tgt_addr, tgt_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_RESET;
            phase         <= SETUP;
            cmd_idx       <= 3'd0;
            op_erase      <= 1'b0;
            byte_sel      <= 1'b0;
            dq5_seen      <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            poll_cnt      <= '0;
            rst_timer     <= '0;
            write_ready   <= 1'b0;
            busy          <= 1'b1;
            error         <= 1'b0;
            flash_a       <= '0;
            flash_d_out   <= '0;
            flash_d_oe    <= 1'b0;
            flash_we_n    <= 1'b1;
            flash_oe_n    <= 1'b1;
            flash_reset_n <= 1'b0;
        end else begin
            write_ready <= 1'b0;
            case (state)
                S_RESET: begin
                    if (rst_timer != RT_W'(RESET_TICKS)) rst_timer <= rst_timer + 1'b1;
                    if (rst_timer == RT_W'(RESET_TICKS - 1)) flash_reset_n <= 1'b1;
                    if (tick && flash_reset_n) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!busy) begin
                        if (erase_req || write_req) begin
                            busy     <= 1'b1;
                            error    <= 1'b0;
                            op_erase <= erase_req;
                            req_addr <= erase_req ? erase_addr : write_addr;
                            req_data <= write_data;
                            byte_sel <= 1'b0;
                        end
                    end else if (tick) begin
                        state       <= S_CMD;
                        phase       <= SETUP;
                        cmd_idx     <= 3'd0;
                        flash_a     <= start_cmd.addr;
                        flash_d_out <= start_cmd.data;
                        flash_d_oe  <= 1'b1;
                        flash_we_n  <= 1'b1;
                        flash_oe_n  <= 1'b1;
                    end
                end
                S_CMD: if (tick) begin
                    case (phase)
                        SETUP: begin phase <= PULSE; flash_we_n <= 1'b0; end
                        PULSE: begin phase <= HOLD;  flash_we_n <= 1'b1; end
                        default: begin
                            if (last_cmd) begin
                                state      <= S_POLL;
                                flash_d_oe <= 1'b0;
                                flash_oe_n <= 1'b0;
                                flash_a    <= tgt_addr;
                                poll_cnt   <= '0;
                                dq5_seen   <= 1'b0;
                            end else begin
                                cmd_idx     <= next_idx;
                                phase       <= SETUP;
                                flash_a     <= next_cmd.addr;
                                flash_d_out <= next_cmd.data;
                            end
                        end
                    endcase
                end
                S_POLL: if (tick) begin
                    if (flash_d_in[7] == poll_exp) begin
                        flash_oe_n <= 1'b1;
                        if (!op_erase && !byte_sel) begin
                            byte_sel    <= 1'b1;
                            state       <= S_CMD;
                            phase       <= SETUP;
                            cmd_idx     <= 3'd0;
                            flash_a     <= start_cmd.addr;
                            flash_d_out <= start_cmd.data;
                            flash_d_oe  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (dq5_seen || (!flash_d_in[5] && poll_cnt >= POLL_LIMIT - 20'd1)) begin
                        // Reset-to-read command; the address is a don't-care.
                        state       <= S_ABORT;
                        phase       <= SETUP;
                        flash_a     <= CMD_ADDR_AAA;
                        flash_d_out <= DATA_F0;
                        flash_d_oe  <= 1'b1;
                        flash_oe_n  <= 1'b1;
                    end else begin
                        if (flash_d_in[5]) dq5_seen <= 1'b1;
                        poll_cnt <= (poll_cnt == '1) ? poll_cnt : poll_cnt + 20'd1;
                    end
                end
                S_DONE: if (tick) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    write_ready <= 1'b1;
                end
                S_ABORT: if (tick) begin
                    case (phase)
                        SETUP: begin phase <= PULSE; flash_we_n <= 1'b0; end
                        PULSE: begin phase <= HOLD;  flash_we_n <= 1'b1; end
                        default: begin
                            flash_d_oe  <= 1'b0;
                            error       <= 1'b1;
                            write_ready <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end
                    endcase
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_de1_flash_writer.sv
// Directed bench for de1_flash_writer with a behavioural NOR flash poll model and scoreboard.
module tb_de1_flash_writer;
    import de1_flash_pkg::*;

    localparam int CLK_DIV     = 5;
    localparam int RESET_TICKS = 500;

    logic        clk, rst;
    logic        write_req, erase_req;
    logic [20:0] write_addr, erase_addr;
    logic [15:0] write_data;
    logic        write_ready, busy, error;
    logic [21:0] flash_a;
    logic [7:0]  flash_d_out, flash_d_in;
    logic        flash_d_oe, flash_we_n, flash_reset_n, flash_ce_n, flash_oe_n;

    de1_flash_writer #(
        .CLK_DIV(CLK_DIV), .RESET_TICKS(RESET_TICKS), .POLL_LIMIT(20'd1000000)
    ) dut (
        .clk(clk), .rst(rst),
        .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
        .erase_req(erase_req), .erase_addr(erase_addr),
        .write_ready(write_ready), .busy(busy), .error(error),
        .flash_a(flash_a), .flash_d_out(flash_d_out), .flash_d_in(flash_d_in),
        .flash_d_oe(flash_d_oe), .flash_we_n(flash_we_n), .flash_reset_n(flash_reset_n),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [30:0] exp_q[$];        // {addr_care, addr, data} per bus write
    logic [0:0]  exp_ready_q[$];  // expected error flag at each write_ready
    int          exp_poll_q[$];   // expected clks of each oe_n-low poll window

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- flash poll model ----------------
    logic       model_erase = 1'b0;
    logic       model_fault = 1'b0;
    int         mis_ticks = 0;
    int         poll_clks = 0;
    logic [7:0] last_pd = 8'h00;

    always @(posedge clk) poll_clks <= flash_oe_n ? 0 : poll_clks + 1;

    assign flash_d_in = model_fault ? 8'h20 :
                        (poll_clks < mis_ticks * CLK_DIV) ?
                            (model_erase ? 8'h00 : {~last_pd[7], 7'b0}) :
                            (model_erase ? 8'hFF : last_pd);

    // ---------------- monitor ----------------
    int wr_count = 0, ready_count = 0, drop_req = 0, drop_done = 0, bus_bad = 0;
    int we_low = 0, oe_low = 0;
    logic prev_we = 1'b1, prev_oe = 1'b1, prev_ready = 1'b0;
    logic [30:0] mon_e;
    int          mon_p;
    logic [0:0]  mon_r;

    always @(negedge clk) begin
        if (!flash_we_n && (!flash_d_oe || !flash_oe_n)) bus_bad++;
        if (!flash_oe_n && flash_d_oe) bus_bad++;

        if (!flash_we_n) begin
            we_low++;
        end else if (!prev_we) begin
            if (drop_done < drop_req) begin
                drop_done++;
            end else begin
                wr_count++;
                last_pd = flash_d_out;
                check("we_n low clks", we_low, CLK_DIV);
                check("bus write expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("bus write data", flash_d_out, mon_e[7:0]);
                    if (mon_e[30]) check("bus write addr", flash_a, mon_e[29:8]);
                end
            end
            we_low = 0;
        end
        prev_we = flash_we_n;

        if (!flash_oe_n) begin
            oe_low++;
        end else if (!prev_oe) begin
            check("poll expected", exp_poll_q.size() > 0, 1);
            if (exp_poll_q.size() > 0) begin
                mon_p = exp_poll_q.pop_front();
                check("poll window clks", oe_low, mon_p);
            end
            oe_low = 0;
        end
        prev_oe = flash_oe_n;

        if (write_ready) begin
            ready_count++;
            check("write_ready width", prev_ready, 0);
            check("busy low at write_ready", busy, 0);
            check("write_ready expected", exp_ready_q.size() > 0, 1);
            if (exp_ready_q.size() > 0) begin
                mon_r = exp_ready_q.pop_front();
                check("error at write_ready", error, mon_r);
            end
        end
        prev_ready = write_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic push_wr(input logic care, input logic [21:0] a, input logic [7:0] d);
        exp_q.push_back({care, a, d});
    endtask

    task automatic push_prog(input logic [21:0] pa, input logic [7:0] pd);
        push_wr(1'b1, 22'h000AAA, 8'hAA);
        push_wr(1'b1, 22'h000555, 8'h55);
        push_wr(1'b1, 22'h000AAA, 8'hA0);
        push_wr(1'b1, pa, pd);
    endtask

    task automatic push_erase(input logic [21:0] sa);
        push_wr(1'b1, 22'h000AAA, 8'hAA);
        push_wr(1'b1, 22'h000555, 8'h55);
        push_wr(1'b1, 22'h000AAA, 8'h80);
        push_wr(1'b1, 22'h000AAA, 8'hAA);
        push_wr(1'b1, 22'h000555, 8'h55);
        push_wr(1'b1, sa, 8'h30);
    endtask

    task automatic apply_reset();
        int low, waited, bad;
        rst = 1'b1;
        @(negedge clk);
        check("reset busy", busy, 1);
        check("reset write_ready", write_ready, 0);
        check("reset error", error, 0);
        check("reset we_n", flash_we_n, 1);
        check("reset oe_n", flash_oe_n, 1);
        check("reset d_oe", flash_d_oe, 0);
        check("reset flash_reset_n", flash_reset_n, 0);
        check("ce_n tied low", flash_ce_n, 0);
        rst = 1'b0;
        low = 0;
        bad = 0;
        while (!flash_reset_n && low < 2000) begin
            low++;
            if (!flash_we_n || !flash_oe_n || flash_d_oe || !busy || write_ready) bad++;
            @(negedge clk);
        end
        check("flash_reset_n low clks", low, RESET_TICKS);
        check("strobes quiet in reset", bad, 0);
        waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("busy falls within 2 ticks", waited <= 2 * CLK_DIV, 1);
        check("busy after reset", busy, 0);
    endtask

    task automatic issue(input logic w, input logic e, input logic [20:0] wa,
                         input logic [15:0] wd, input logic [20:0] ea);
        @(negedge clk);
        write_req = w; erase_req = e;
        write_addr = wa; write_data = wd; erase_addr = ea;
        @(negedge clk);
        write_req = 1'b0; erase_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("operation done in budget", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " bus writes drained"}, exp_q.size(), 0);
        check({tag, " polls drained"}, exp_poll_q.size(), 0);
        check({tag, " readies drained"}, exp_ready_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    int rc0, base, n;

    initial begin
        rst = 1'b1;
        write_req = 1'b0; erase_req = 1'b0;
        write_addr = '0; write_data = '0; erase_addr = '0;

        apply_reset();

        // Word write with three mismatching poll samples per byte.
        model_erase = 1'b0; model_fault = 1'b0; mis_ticks = 3;
        push_prog(22'h000020, 8'hEF);
        push_prog(22'h000021, 8'hBE);
        exp_poll_q.push_back(4 * CLK_DIV);
        exp_poll_q.push_back(4 * CLK_DIV);
        exp_ready_q.push_back(1'b0);
        rc0 = ready_count;
        issue(1'b1, 1'b0, 21'h000010, 16'hBEEF, 21'h0);
        wait_done(3000);
        check("write ready count", ready_count - rc0, 1);
        check("write error", error, 0);
        check_drained("write");

        // Word 0x012345 is byte 0x02468A, inside the 64 KB sector at byte 0x020000.
        model_erase = 1'b1; mis_ticks = 100;
        push_erase(22'h020000);
        exp_poll_q.push_back(101 * CLK_DIV);
        exp_ready_q.push_back(1'b0);
        rc0 = ready_count;
        issue(1'b0, 1'b1, 21'h0, 16'h0, 21'h012345);
        wait_done(4000);
        check("erase ready count", ready_count - rc0, 1);
        check_drained("erase");

        // DQ5 fault: one resample, then reset-to-read, no high byte.
        model_erase = 1'b0; model_fault = 1'b1;
        push_prog(22'h00000A, 8'h80);
        push_wr(1'b0, 22'h0, 8'hF0);
        exp_poll_q.push_back(2 * CLK_DIV);
        exp_ready_q.push_back(1'b1);
        rc0 = ready_count;
        issue(1'b1, 1'b0, 21'h000005, 16'h8080, 21'h0);
        wait_done(3000);
        check("fault ready count", ready_count - rc0, 1);
        check("error sticky after abort", error, 1);
        check_drained("fault");

        // Simultaneous requests: erase wins; a write while busy is ignored.
        model_fault = 1'b0; model_erase = 1'b1; mis_ticks = 2;
        push_erase(22'h3E0000);
        exp_poll_q.push_back(3 * CLK_DIV);
        exp_ready_q.push_back(1'b0);
        rc0 = ready_count;
        issue(1'b1, 1'b1, 21'h000100, 16'h1234, 21'h1F0000);
        check("busy after capture", busy, 1);
        check("error cleared on capture", error, 0);
        repeat (20) @(negedge clk);
        check("busy mid erase", busy, 1);
        issue(1'b1, 1'b0, 21'h000200, 16'h5678, 21'h0);
        wait_done(3000);
        check("collision ready count", ready_count - rc0, 1);
        check_drained("collision");

        // Reset during the third bus cycle of a program.
        model_erase = 1'b0; mis_ticks = 0;
        push_prog(22'h000040, 8'h11);
        rc0 = ready_count;
        base = wr_count;
        issue(1'b1, 1'b0, 21'h000020, 16'h2211, 21'h0);
        n = 0;
        while (!(wr_count == base + 2 && !flash_we_n) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("third bus cycle reached", wr_count == base + 2 && !flash_we_n, 1);
        drop_req++;
        exp_q.delete();
        apply_reset();
        check("no ready after mid-op reset", ready_count - rc0, 0);
        check_drained("mid-op reset");

        check("no bus contention", bus_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
